// File: rtl/ah_range_decoder.sv
// Programmable range decoder: matches each accepted field against NUM_CLIENTS
// inclusive ranges and registers a priority-resolved select. Error counter is
// built only when AH_RANGE_DEC_ERR_CNT_EN is defined.
module ah_range_decoder #(
  parameter int FIELD_W     = 10,
  parameter int NUM_CLIENTS = 20,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [FIELD_W-1:0]     cfg_bom,
  input  logic [FIELD_W-1:0]     cfg_tom,
  input  logic                   cfg_ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FIELD_W-1:0]     in_field,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CLIENTS-1:0] out_onehot,
  output logic [IDX_W-1:0]       out_bin,
  output logic                   out_multi,
  output logic                   out_err,
  output logic [15:0]            err_cnt,
  input  logic                   err_cnt_clr
);

  typedef struct packed {
    logic               ena;
    logic [FIELD_W-1:0] bom;
    logic [FIELD_W-1:0] tom;
  } entry_t;

  entry_t rng_tbl [NUM_CLIENTS];

  // NOTE: the table is plain flops, so it is reset like any other state; a
  // mid-operation reset must leave every range disabled and non-matching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLIENTS; i++)
        rng_tbl[i] <= '{ena: 1'b0, bom: '1, tom: '0};
    end else if (cfg_we) begin
      // Indices >= NUM_CLIENTS match no entry and are dropped here.
      for (int i = 0; i < NUM_CLIENTS; i++)
        if (cfg_idx == IDX_W'(i))
          rng_tbl[i] <= '{ena: cfg_ena, bom: cfg_bom, tom: cfg_tom};
    end
  end

  logic [NUM_CLIENTS-1:0] match;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++)
      match[i] = rng_tbl[i].ena && (in_field >= rng_tbl[i].bom) &&
                 (in_field <= rng_tbl[i].tom);
  end

  logic [NUM_CLIENTS-1:0] dec_onehot;
  logic [IDX_W-1:0]       dec_bin;
  logic                   dec_multi;
  logic                   found;

  // NOTE: blocking assignments in combinational logic; 'found' must carry the
  // result of earlier iterations into later ones within the same evaluation.
  always_comb begin
    dec_onehot = '0;
    dec_bin    = '0;
    dec_multi  = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (match[i] && found)
        dec_multi = 1'b1;
      if (match[i] && !found) begin
        dec_onehot[i] = 1'b1;
        dec_bin       = IDX_W'(i);
      end
      found = found | match[i];
    end
  end

  logic accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_bin    <= '0;
      out_multi  <= 1'b0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_onehot <= dec_onehot;
      out_bin    <= dec_bin;
      out_multi  <= dec_multi;
      out_err    <= ~found;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef AH_RANGE_DEC_ERR_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (err_cnt_clr)
      cnt_q <= '0;
    else if (out_valid && out_ready && out_err && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign err_cnt = cnt_q;
`else
  logic unused_clr;

  assign unused_clr = err_cnt_clr;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_ah_range_decoder.sv
// Directed self-checking bench for ah_range_decoder; expectations are hand
// computed from the range table the bench programs.
module tb_ah_range_decoder;

  localparam int FW = 10;
  localparam int NC = 20;
  localparam int IW = $clog2(NC);

`ifdef AH_RANGE_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [FW-1:0] cfg_bom;
  logic [FW-1:0] cfg_tom;
  logic          cfg_ena;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_field;
  logic          out_valid;
  logic          out_ready;
  logic [NC-1:0] out_onehot;
  logic [IW-1:0] out_bin;
  logic          out_multi;
  logic          out_err;
  logic [15:0]   err_cnt;
  logic          err_cnt_clr;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  ah_range_decoder #(.FIELD_W(FW), .NUM_CLIENTS(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_bom(cfg_bom),
    .cfg_tom(cfg_tom), .cfg_ena(cfg_ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_field(in_field),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_bin(out_bin), .out_multi(out_multi),
    .out_err(out_err), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input int bom, input int tom, input bit ena);
    cfg_we  = 1'b1;
    cfg_idx = IW'(idx);
    cfg_bom = FW'(bom);
    cfg_tom = FW'(tom);
    cfg_ena = ena;
    @(posedge clk); #1;
    cfg_we  = 1'b0;
  endtask

  task automatic bump_err();
    if (CNT_EN && exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic check_result(input string tag, input int oh, input int bin,
                              input bit multi, input bit err);
    check({tag, ".valid"},  32'(out_valid),  1);
    check({tag, ".onehot"}, 32'(out_onehot), oh);
    check({tag, ".bin"},    32'(out_bin),    bin);
    check({tag, ".multi"},  32'(out_multi),  32'(multi));
    check({tag, ".err"},    32'(out_err),    32'(err));
  endtask

  // One field through the pipe with out_ready held high: result, then drain.
  task automatic send(input string tag, input int field, input int oh,
                      input int bin, input bit multi, input bit err);
    in_valid = 1'b1;
    in_field = FW'(field);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_result(tag, oh, bin, multi, err);
    @(posedge clk); #1;
    if (err) bump_err();
    check({tag, ".drain"}, 32'(out_valid), 0);
    check({tag, ".cnt"},   32'(err_cnt),   exp_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_bom     = '0;
    cfg_tom     = '0;
    cfg_ena     = 1'b0;
    in_valid    = 1'b0;
    in_field    = '0;
    out_ready   = 1'b1;
    err_cnt_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready),   1);
    check("rst.out_valid", 32'(out_valid),  0);
    check("rst.onehot",    32'(out_onehot), 0);
    check("rst.bin",       32'(out_bin),    0);
    check("rst.multi",     32'(out_multi),  0);
    check("rst.err",       32'(out_err),    0);
    check("rst.err_cnt",   32'(err_cnt),    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty table: everything is a decode error.
    send("empty", 'h005, 0, 0, 1'b0, 1'b1);

    // Single range, both inclusive edges and one step outside each.
    cfg_write(3, 'h100, 'h1FF, 1'b1);
    send("r3_below", 'h0FF, 0,     0, 1'b0, 1'b1);
    send("r3_lo",    'h100, 'h008, 3, 1'b0, 1'b0);
    send("r3_hi",    'h1FF, 'h008, 3, 1'b0, 1'b0);
    send("r3_above", 'h200, 0,     0, 1'b0, 1'b1);

    // Overlap: lower index wins, multi flags the second hit.
    cfg_write(2, 'h000, 'h3FF, 1'b1);
    cfg_write(7, 'h050, 'h060, 1'b1);
    send("overlap", 'h055, 'h004, 2, 1'b1, 1'b0);
    send("ov_r3",   'h180, 'h004, 2, 1'b1, 1'b0);

    // Disabling entry 2 leaves entry 7 alone.
    cfg_write(2, 'h000, 'h3FF, 1'b0);
    send("r7_only", 'h055, 'h080, 7, 1'b0, 1'b0);
    send("r7_hi",   'h060, 'h080, 7, 1'b0, 1'b0);

    // Inverted range never matches; out-of-range index is ignored.
    cfg_write(9, 'h020, 'h010, 1'b1);
    send("inverted", 'h018, 0, 0, 1'b0, 1'b1);
    cfg_write(25, 'h000, 'h3FF, 1'b1);
    send("bad_idx", 'h300, 0, 0, 1'b0, 1'b1);

    // Write and accept in the same cycle: old table applies.
    cfg_we   = 1'b1;
    cfg_idx  = IW'(5);
    cfg_bom  = FW'('h010);
    cfg_tom  = FW'('h010);
    cfg_ena  = 1'b1;
    in_valid = 1'b1;
    in_field = FW'('h010);
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    check_result("collide", 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bump_err();
    check("collide.cnt", 32'(err_cnt), exp_cnt);
    send("after_collide", 'h010, 'h020, 5, 1'b0, 1'b0);

    // Backpressure: first result held five cycles, then the rest stream out.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_field  = FW'('h150);
    @(posedge clk); #1;
    check_result("bp0", 'h008, 3, 1'b0, 1'b0);
    check("bp0.in_ready", 32'(in_ready), 0);
    in_field = FW'('h010);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_result("bp_hold", 'h008, 3, 1'b0, 1'b0);
      check("bp_hold.in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_comb", 32'(in_ready), 1);
    @(posedge clk); #1;
    check_result("bp1", 'h020, 5, 1'b0, 1'b0);
    in_field = FW'('h055);
    @(posedge clk); #1;
    check_result("bp2", 'h080, 7, 1'b0, 1'b0);
    in_field = FW'('h300);
    @(posedge clk); #1;
    check_result("bp3", 0, 0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    bump_err();
    check("bp.drain", 32'(out_valid), 0);
    check("bp.cnt",   32'(err_cnt),   exp_cnt);

`ifdef AH_RANGE_DEC_ERR_CNT_EN
    // Back-to-back errors well past the saturation point.
    in_valid = 1'b1;
    in_field = FW'('h300);
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 65535;
    check("sat.cnt", 32'(err_cnt), exp_cnt);
`endif

    // Clear together with an error handshake: clear wins.
    in_valid = 1'b1;
    in_field = FW'('h300);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    err_cnt_clr = 1'b1;
    @(posedge clk); #1;
    err_cnt_clr = 1'b0;
    exp_cnt     = 0;
    check("clr.cnt",   32'(err_cnt),   exp_cnt);
    check("clr.valid", 32'(out_valid), 0);
    send("post_clr", 'h300, 0, 0, 1'b0, 1'b1);

    // Reset with a result pending.
    in_valid = 1'b1;
    in_field = FW'('h150);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid.valid_pre", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("mid.valid",    32'(out_valid), 0);
    check("mid.in_ready", 32'(in_ready),  1);
    check("mid.bin",      32'(out_bin),   0);
    check("mid.cnt",      32'(err_cnt),   exp_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("mid.tbl_cleared", 'h150, 0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
